// File: rtl/issue_dispatch_queue_pkg.sv
// Shared issue-stage types and helpers.
//   RobIdx            : ROB pointer with a wrap (dir) bit
//   IssueStatusBundle : renamed micro-op status written into the issue banks
//   rob_older()       : true when ROB entry a is older than a redirect point
//   wakeup_hit()      : true when any writeback on the wakeup bus targets rs
package issue_dispatch_queue_pkg;

  localparam int unsigned PREG_WIDTH    = 6;
  localparam int unsigned WB_SIZE       = 2;
  localparam int unsigned ROB_IDX_WIDTH = 5;

  typedef struct packed {
    logic                     dir;
    logic [ROB_IDX_WIDTH-1:0] idx;
  } RobIdx;

  typedef struct packed {
    logic                  rs1v;
    logic [PREG_WIDTH-1:0] rs1;
    logic                  rs2v;
    logic [PREG_WIDTH-1:0] rs2;
    logic                  we;
    logic [PREG_WIDTH-1:0] rd;
    RobIdx                 robIdx;
  } IssueStatusBundle;

  // Equal dir: older when idx is below the redirect point; differing dir inverts that.
  function automatic logic rob_older(input RobIdx a, input RobIdx redir);
    return (a.dir ^ redir.dir) ^ (redir.idx > a.idx);
  endfunction

  function automatic logic wakeup_hit(input logic [PREG_WIDTH-1:0]              rs,
                                      input logic [WB_SIZE-1:0]                 en,
                                      input logic [WB_SIZE-1:0]                 we,
                                      input logic [WB_SIZE-1:0][PREG_WIDTH-1:0] rd);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WB_SIZE; j++) begin
      hit = hit | (en[j] & we[j] & (rd[j] == rs));
    end
    return hit;
  endfunction

endpackage

// File: rtl/issue_dispatch_queue_bank_steer_select.sv
// Combinational bank selector: arg-min of bank_num over banks that are not
// full, ties resolved to the lowest index.
//   bank_num  : per-bank occupancy
//   bank_full : per-bank full flag
//   sel       : one-hot selected bank (zero when every bank is full)
//   any_free  : at least one bank can accept a write
module bank_steer_select
  import issue_dispatch_queue_pkg::*;
#(
  parameter int unsigned BANK_NUM  = 2,
  parameter int unsigned NUM_WIDTH = 4
) (
  input  logic [BANK_NUM-1:0][NUM_WIDTH-1:0] bank_num,
  input  logic [BANK_NUM-1:0]                bank_full,
  output logic [BANK_NUM-1:0]                sel,
  output logic                               any_free
);

  logic [NUM_WIDTH-1:0] best_num;

  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    best_num = '0;
    for (int i = 0; i < BANK_NUM; i++) begin
      // Strict less-than keeps the earlier (lower) index on a tie.
      if (!bank_full[i] && (!any_free || (bank_num[i] < best_num))) begin
        sel      = '0;
        sel[i]   = 1'b1;
        best_num = bank_num[i];
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_dispatch_queue.sv
// In-order dispatch FIFO in front of a group of issue banks.
//   in_valid/in_ready/in_status/in_data : renamed micro-op input
//   bank_en/bank_status/bank_data        : write port driven into the banks
//   bank_full/bank_num                   : per-bank full flag and occupancy
//   wakeup_en/wakeup_we/wakeup_rd        : writeback bus snooped by all entries
//   redirect/redirect_idx                : backend flush of younger entries
//   count                                : current FIFO occupancy
module issue_dispatch_queue
  import issue_dispatch_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned BANK_NUM   = 2,
  parameter int unsigned BANK_DEPTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  IssueStatusBundle                           in_status,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  output logic [BANK_NUM-1:0]                        bank_en,
  output IssueStatusBundle                           bank_status,
  output logic [DATA_WIDTH-1:0]                      bank_data,
  input  logic [BANK_NUM-1:0]                        bank_full,
  input  logic [BANK_NUM-1:0][$clog2(BANK_DEPTH):0]  bank_num,
  input  logic [WB_SIZE-1:0]                         wakeup_en,
  input  logic [WB_SIZE-1:0]                         wakeup_we,
  input  logic [WB_SIZE-1:0][PREG_WIDTH-1:0]         wakeup_rd,
  input  logic                                       redirect,
  input  RobIdx                                      redirect_idx,
  output logic [$clog2(DEPTH):0]                     count
);

  localparam int unsigned ADDR      = $clog2(DEPTH);
  localparam int unsigned PTR_W     = ADDR + 1;
  localparam int unsigned NUM_WIDTH = $clog2(BANK_DEPTH) + 1;

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, kept, scan_ptr;
  logic [ADDR-1:0]       head_idx, tail_idx;
  IssueStatusBundle      status_q [DEPTH];
  IssueStatusBundle      status_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [DEPTH];
  IssueStatusBundle      in_woken;
  logic [DEPTH-1:0]      entry_valid;
  logic [BANK_NUM-1:0]   steer_sel;
  logic                  any_free, empty, enq, deq;

  bank_steer_select #(
    .BANK_NUM  (BANK_NUM),
    .NUM_WIDTH (NUM_WIDTH)
  ) u_steer (
    .bank_num  (bank_num),
    .bank_full (bank_full),
    .sel       (steer_sel),
    .any_free  (any_free)
  );

  assign count    = tail_q - head_q;
  assign head_idx = head_q[ADDR-1:0];
  assign tail_idx = tail_q[ADDR-1:0];
  assign empty    = (count == '0);
  assign in_ready = (count != PTR_W'(DEPTH)) & ~redirect;
  assign enq      = in_valid & in_ready;
  assign bank_en  = (!empty && !redirect && any_free) ? steer_sel : '0;
  assign deq      = |bank_en;

  // Entry valid is derived from the pointers, so reset clears it for free.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = PTR_W'(ADDR'(i) - head_idx) < count;
    end
  end

  // Kept entries on a redirect form a prefix from head; count them.
  always_comb begin
    kept     = '0;
    scan_ptr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_ptr = head_q + PTR_W'(i);
      if ((PTR_W'(i) < count) &&
          rob_older(status_q[scan_ptr[ADDR-1:0]].robIdx, redirect_idx)) begin
        kept = kept + PTR_W'(1);
      end
    end
  end

  always_comb begin
    in_woken      = in_status;
    in_woken.rs1v = in_status.rs1v | wakeup_hit(in_status.rs1, wakeup_en, wakeup_we, wakeup_rd);
    in_woken.rs2v = in_status.rs2v | wakeup_hit(in_status.rs2, wakeup_en, wakeup_we, wakeup_rd);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      status_d[i] = status_q[i];
      if (enq && (tail_idx == ADDR'(i))) begin
        status_d[i] = in_woken;
      end else if (entry_valid[i]) begin
        status_d[i].rs1v = status_q[i].rs1v |
                           wakeup_hit(status_q[i].rs1, wakeup_en, wakeup_we, wakeup_rd);
        status_d[i].rs2v = status_q[i].rs2v |
                           wakeup_hit(status_q[i].rs2, wakeup_en, wakeup_we, wakeup_rd);
      end
    end
  end

  // The bank captures status without snooping, so fold in this cycle's wakeups.
  always_comb begin
    bank_status      = status_q[head_idx];
    bank_status.rs1v = status_q[head_idx].rs1v |
                       wakeup_hit(status_q[head_idx].rs1, wakeup_en, wakeup_we, wakeup_rd);
    bank_status.rs2v = status_q[head_idx].rs2v |
                       wakeup_hit(status_q[head_idx].rs2, wakeup_en, wakeup_we, wakeup_rd);
    bank_data        = data_q[head_idx];
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (redirect) begin
      tail_d = head_q + kept;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      status_q[i] <= status_d[i];
      if (enq && (tail_idx == ADDR'(i))) data_q[i] <= in_data;
    end
  end

endmodule

// File: tb/tb_issue_dispatch_queue.sv
module tb_issue_dispatch_queue;
  import issue_dispatch_queue_pkg::*;

  localparam int unsigned DATA_WIDTH = 1;
  localparam int unsigned BANK_NUM   = 2;
  localparam int unsigned BANK_DEPTH = 8;
  localparam int unsigned DEPTH      = 4;

  logic                                 clk = 1'b0;
  logic                                 rst = 1'b1;
  logic                                 in_valid;
  logic                                 in_ready;
  IssueStatusBundle                     in_status;
  logic [DATA_WIDTH-1:0]                in_data;
  logic [BANK_NUM-1:0]                  bank_en;
  IssueStatusBundle                     bank_status;
  logic [DATA_WIDTH-1:0]                bank_data;
  logic [BANK_NUM-1:0]                  bank_full;
  logic [BANK_NUM-1:0][3:0]             bank_num;
  logic [WB_SIZE-1:0]                   wakeup_en, wakeup_we;
  logic [WB_SIZE-1:0][PREG_WIDTH-1:0]   wakeup_rd;
  logic                                 redirect;
  RobIdx                                redirect_idx;
  logic [2:0]                           count;

  typedef struct packed {
    RobIdx                 rob;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  issue_dispatch_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .BANK_NUM   (BANK_NUM),
    .BANK_DEPTH (BANK_DEPTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_status    (in_status),
    .in_data      (in_data),
    .bank_en      (bank_en),
    .bank_status  (bank_status),
    .bank_data    (bank_data),
    .bank_full    (bank_full),
    .bank_num     (bank_num),
    .wakeup_en    (wakeup_en),
    .wakeup_we    (wakeup_we),
    .wakeup_rd    (wakeup_rd),
    .redirect     (redirect),
    .redirect_idx (redirect_idx),
    .count        (count)
  );

  // Every bank write is matched in order against the expected program-order stream.
  always @(negedge clk) begin
    if (!rst && (bank_en != '0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: bank_en=%b rob=%h with nothing expected", bank_en,
                 bank_status.robIdx);
      end else begin
        mon_e = sb.pop_front();
        if ((bank_status.robIdx !== mon_e.rob) || (bank_data !== mon_e.data)) begin
          errors++;
          $display("FAIL sb_order: got rob=%h data=%b want rob=%h data=%b",
                   bank_status.robIdx, bank_data, mon_e.rob, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic tb_older(input RobIdx a, input RobIdx r);
    return (a.dir != r.dir) ^ (r.idx > a.idx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_status    = '0;
    in_data      = '0;
    wakeup_en    = '0;
    wakeup_we    = '0;
    wakeup_rd    = '0;
    redirect     = 1'b0;
    redirect_idx = '0;
  endtask

  // Drives one micro-op for the current cycle; the caller checks it is accepted.
  task automatic offer(input logic dir, input logic [4:0] idx, input logic [5:0] rs1,
                       input logic rs1v, input logic [5:0] rs2, input logic rs2v,
                       input logic d);
    exp_t e;
    in_valid              = 1'b1;
    in_status             = '0;
    in_status.robIdx.dir  = dir;
    in_status.robIdx.idx  = idx;
    in_status.rs1         = rs1;
    in_status.rs1v        = rs1v;
    in_status.rs2         = rs2;
    in_status.rs2v        = rs2v;
    in_data               = d;
    e.rob.dir             = dir;
    e.rob.idx             = idx;
    e.data                = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    bank_full = '0;
    for (int k = 0; (k < 12) && (count != 3'd0); k++) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    bank_full = '0;
    bank_num  = '0;
    #25;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (bank_en !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", bank_en); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count: got %0d want 0", count); end
    checks++; if (bank_en !== 2'b00) begin errors++; $display("FAIL idle_en: got %b want 00", bank_en); end
  endtask

  task automatic test_latency();
    tick();
    offer(1'b0, 5'd1, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b want 1", in_ready); end
    checks++; if (bank_en !== 2'b00) begin errors++; $display("FAIL lat_bypass: got %b want 00", bank_en); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bank_en !== 2'b01) begin errors++; $display("FAIL lat_en: got %b want 01", bank_en); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL lat_count: got %0d want 1", count); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL lat_deq: got %0d want 0", count); end
  endtask

  task automatic test_steering();
    logic [3:0] n0 [5];
    logic [3:0] n1 [5];
    logic [1:0] fl [5];
    logic [1:0] ex [5];
    n0 = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd4};
    n1 = '{4'd5, 4'd4, 4'd3, 4'd4, 4'd4};
    fl = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
    ex = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    bank_full = 2'b11;
    tick();
    offer(1'b0, 5'd2, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      bank_num[0] = n0[k];
      bank_num[1] = n1[k];
      bank_full   = fl[k];
      #1;
      checks++;
      if (bank_en !== ex[k]) begin
        errors++;
        $display("FAIL steer_%0d: num={%0d,%0d} full=%b got %b want %b", k, n0[k], n1[k],
                 fl[k], bank_en, ex[k]);
      end
    end
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL steer_hold: got %0d want 1", count); end
    bank_full = 2'b01;
    #1;
    checks++; if (bank_en !== 2'b10) begin errors++; $display("FAIL steer_release: got %b want 10", bank_en); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL steer_deq: got %0d want 0", count); end
    bank_num  = '0;
    bank_full = '0;
  endtask

  task automatic test_wakeup();
    // Snooped while parked behind full banks.
    bank_full = 2'b11;
    tick();
    offer(1'b0, 5'd3, 6'd7, 1'b0, 6'd0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    tick();
    wakeup_en[0] = 1'b1;
    wakeup_we[0] = 1'b1;
    wakeup_rd[0] = 6'd7;
    tick();
    idle_inputs();
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wk_parked: got %0d want 1", count); end
    bank_full = 2'b00;
    #1;
    checks++; if (bank_en !== 2'b01) begin errors++; $display("FAIL wk_en: got %b want 01", bank_en); end
    checks++; if (bank_status.rs1v !== 1'b1) begin errors++; $display("FAIL wk_snoop_rs1v: got %b want 1", bank_status.rs1v); end
    // Wakeup arriving in the dequeue cycle itself.
    tick();
    bank_full = 2'b11;
    offer(1'b0, 5'd4, 6'd1, 1'b1, 6'd9, 1'b0, 1'b0);
    tick();
    idle_inputs();
    bank_full    = 2'b00;
    wakeup_en[1] = 1'b1;
    wakeup_we[1] = 1'b0;
    wakeup_rd[1] = 6'd9;
    #1;
    checks++; if (bank_status.rs2v !== 1'b0) begin errors++; $display("FAIL wk_noweb: got %b want 0", bank_status.rs2v); end
    wakeup_we[1] = 1'b1;
    #1;
    checks++; if (bank_en !== 2'b01) begin errors++; $display("FAIL wk_same_en: got %b want 01", bank_en); end
    checks++; if (bank_status.rs2v !== 1'b1) begin errors++; $display("FAIL wk_same_rs2v: got %b want 1", bank_status.rs2v); end
    // Wakeup coinciding with the enqueue.
    tick();
    idle_inputs();
    bank_full = 2'b11;
    offer(1'b0, 5'd5, 6'd12, 1'b0, 6'd13, 1'b0, 1'b1);
    wakeup_en[0] = 1'b1;
    wakeup_we[0] = 1'b1;
    wakeup_rd[0] = 6'd12;
    tick();
    idle_inputs();
    bank_full = 2'b00;
    #1;
    checks++; if (bank_status.rs1v !== 1'b1) begin errors++; $display("FAIL wk_enq_rs1v: got %b want 1", bank_status.rs1v); end
    checks++; if (bank_status.rs2v !== 1'b0) begin errors++; $display("FAIL wk_enq_rs2v: got %b want 0", bank_status.rs2v); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wk_deq: got %0d want 0", count); end
  endtask

  task automatic test_fill();
    bank_full = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      offer(1'b0, 5'(6 + k), 6'd0, 1'b1, 6'd0, 1'b1, k[0]);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", k, in_ready); end
    end
    tick();
    idle_inputs();
    in_valid             = 1'b1;
    in_status.robIdx.idx = 5'd31;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", in_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_reject: got %0d want 4", count); end
    bank_full = 2'b10;
    #1;
    checks++; if (bank_en !== 2'b01) begin errors++; $display("FAIL fill_deq_en: got %b want 01", bank_en); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_three: got %0d want 3", count); end
    offer(1'b0, 5'd10, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_both_ready: got %b want 1", in_ready); end
    checks++; if (bank_en !== 2'b01) begin errors++; $display("FAIL fill_both_en: got %b want 01", bank_en); end
    tick();
    idle_inputs();
    bank_full = 2'b11;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_both_count: got %0d want 3", count); end
    drain();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drain: got %0d want 0", count); end
  endtask

  task automatic test_redirect(input logic [3:0][5:0] ops, input RobIdx r);
    exp_t keep[$];
    logic stop;
    bank_full = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      offer(ops[k][5], ops[k][4:0], 6'd0, 1'b1, 6'd0, 1'b1, k[0]);
    end
    tick();
    idle_inputs();
    bank_full    = 2'b00;
    redirect     = 1'b1;
    redirect_idx = r;
    #1;
    checks++; if (bank_en !== 2'b00) begin errors++; $display("FAIL redir_en: got %b want 00", bank_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL redir_ready: got %b want 0", in_ready); end
    stop = 1'b0;
    foreach (sb[k]) begin
      if (!stop && tb_older(sb[k].rob, r)) keep.push_back(sb[k]);
      else stop = 1'b1;
    end
    sb = keep;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== 3'(keep.size())) begin
      errors++;
      $display("FAIL redir_count: got %0d want %0d", count, keep.size());
    end
    offer(r.dir, r.idx, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    drain();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_drain: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    bank_full = 2'b00;
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      tick();
      offer(1'b0, 5'(16 + k), 6'd0, 1'b1, 6'd0, 1'b1, k[0]);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_%0d: got %b want 1", k, in_ready); end
    end
    tick();
    idle_inputs();
    drain();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_drain: got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    bank_full = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      offer(1'b1, 5'(k), 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);
    end
    tick();
    idle_inputs();
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL ar_pre_count: got %0d want 3", count); end
    bank_full = 2'b00;
    #1;
    checks++; if (bank_en !== 2'b01) begin errors++; $display("FAIL ar_pre_en: got %b want 01", bank_en); end
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", count); end
    checks++; if (bank_en !== 2'b00) begin errors++; $display("FAIL ar_en: got %b want 00", bank_en); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", in_ready); end
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_after: got %0d want 0", count); end
  endtask

  initial begin
    RobIdx r;
    test_reset();
    test_latency();
    test_steering();
    test_wakeup();
    test_fill();
    r.dir = 1'b0; r.idx = 5'd4;
    test_redirect({6'd5, 6'd4, 6'd3, 6'd2}, r);
    r.dir = 1'b1; r.idx = 5'd1;
    test_redirect({6'b1_00001, 6'b1_00000, 6'b0_11111, 6'b0_11110}, r);
    test_wrap();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
